conv_window_sequencer: RTL and testbench
========================================

# conv_window_sequencer

Controller that sequences the convolution window-shift stage for one image frame. It accepts a raster pixel stream and assembles the FILTER_SIZE-row buffer. It drives the shift stage's `shift_en`/`shift_buffer` controls across each row sweep and watches `new_buffer` to advance to the next row. It sits between the pixel source and the window-shift stage and paces sweeps against a downstream window-consumer ready.

## Interface
- IMAGE_WIDTH, 9, pixels per row
- IMAGE_HEIGHT, 9, rows per frame
- FILTER_SIZE, 3, window edge; requires FILTER_SIZE ≤ IMAGE_WIDTH and FILTER_SIZE ≤ IMAGE_HEIGHT
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a frame; honoured only in IDLE
- pix_data  in  8  pixel, raster order
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  sequencer accepts pixel this cycle (transfer = pix_valid & pix_ready)
- win_ready  in  1  downstream can consume current window this cycle
- new_buffer  in  1  shift stage's end-of-row pulse
- shift_en  out  1  one-cycle row-start pulse to shift stage
- shift_buffer  out  1  window advance; high = current window consumed
- row_buffer_out  out  FILTER_SIZE*IMAGE_WIDTH*8  row r, column c at bits [(r*IMAGE_WIDTH+c)*8 +: 8]; row 0 oldest
- busy  out  1  state ≠ IDLE
- frame_done  out  1  one-cycle pulse after final row sweep
- seq_err  out  1  sticky protocol error, cleared only by rst

## Operation
- Derived: WPR = IMAGE_WIDTH−FILTER_SIZE+1 (windows per row); OUT_ROWS = IMAGE_HEIGHT−FILTER_SIZE+1.
- Counters: col_cnt (0..IMAGE_WIDTH−1), rows_loaded (0..FILTER_SIZE), pulse_cnt (0..WPR), out_row (0..OUT_ROWS). Each is $clog2 sized plus 1 bit, unsigned, with no wrap beyond the stated ranges.
- States and behaviour:
  - IDLE: all outputs low; start → FILL. Clear col_cnt, rows_loaded, out_row.
  - FILL: pix_ready=1. Each transfer writes the staging row at col_cnt. On the transfer at col_cnt=IMAGE_WIDTH−1, commit the row: rows shift up (row r ← row r+1), staging goes to row FILTER_SIZE−1, col_cnt←0, rows_loaded+1. When rows_loaded reaches FILTER_SIZE → START.
  - START: shift_en=1 for exactly one cycle, shift_buffer=0; pulse_cnt←0 → SWEEP.
  - SWEEP: shift_buffer = win_ready (combinational from state and win_ready). Each cycle with shift_buffer=1 increments pulse_cnt. When the WPR-th pulse issues → WAIT_NB.
  - WAIT_NB: outputs low. new_buffer=1 → out_row+1. Then → DONE if out_row+1 = OUT_ROWS, else → LOAD.
  - LOAD: identical to FILL for exactly one row (commit → START). pix_ready=1 only here and in FILL.
  - DONE: frame_done=1 one cycle → IDLE.
- row_buffer_out changes only on a row commit and is stable through START/SWEEP/WAIT_NB.
- Errors (set seq_err, state unaffected):
  - new_buffer high in any state other than WAIT_NB.
  - WAIT_NB lasting more than 2 cycles without new_buffer; in that case also force → IDLE.
- start while busy is ignored.

## Timing
- Reset (async assert, sync use after deassert): state=IDLE, all counters 0, staging and row buffer cleared to 0. pix_ready=0, shift_en=0, shift_buffer=0, busy=0, frame_done=0, seq_err=0.
- rst mid-frame aborts immediately. No partial-frame outputs follow deassertion.
- start sampled in IDLE → FILL next cycle; pix_ready high that cycle.
- Last fill/load transfer at edge N: commit visible and state START at N+1. shift_en is high during cycle N+1, and SWEEP starts at N+2.
- With win_ready held high, SWEEP lasts exactly WPR cycles. new_buffer is expected in the cycle after the final pulse (first WAIT_NB cycle).
- win_ready low stalls SWEEP with no pulse and no count change. Stall length is unbounded.
- Minimum frame with continuous pix_valid and win_ready: IMAGE_WIDTH*FILTER_SIZE + OUT_ROWS*(1+WPR+1) + (OUT_ROWS−1)*IMAGE_WIDTH + 1 cycles from first FILL cycle to frame_done.

## Test plan
- 9x9, F=3, pixels 0..80, pix_valid and win_ready always 1, shift stage attached → 7 shift_en pulses, 49 shift_buffer pulses, 7 new_buffer, 1 frame_done. After fill, row_buffer_out rows = {0..8},{9..17},{18..26}; the final sweep sees {54..62},{63..71},{72..80}; seq_err=0.
- Same frame with win_ready toggling 1,0 each cycle → identical pulse counts and window values, SWEEP takes 13–14 cycles per row, frame_done once.
- pix_valid high one cycle in three → pix_ready held high in FILL/LOAD, row commits only after 9 accepted pixels, row_buffer_out unchanged between commits.
- Assert rst for one cycle during third SWEEP → all outputs 0 next edge. A new start reloads a fresh frame with correct windows.
- Force new_buffer high during FILL → seq_err=1 and stays 1; frame still completes. Withhold new_buffer in WAIT_NB → seq_err=1 and return to IDLE after 2 cycles.
- start pulsed while busy → ignored; one frame_done, counters unaffected.

Source files
------------

// File: rtl/conv_window_sequencer_if.sv
// Pixel-stream and window-shift-stage signals shared by the sequencer and its neighbours.
// The master side is the sequencer; the slave side is the pixel source plus the shift stage.
interface conv_window_sequencer_if #(
  parameter int IMAGE_WIDTH = 9,
  parameter int FILTER_SIZE = 3
);
  logic [7:0]                           pix_data;
  logic                                 pix_valid;
  logic                                 pix_ready;
  logic                                 win_ready;
  logic                                 new_buffer;
  logic                                 shift_en;
  logic                                 shift_buffer;
  logic [FILTER_SIZE*IMAGE_WIDTH*8-1:0] row_buffer_out;

  modport master (
    input  pix_data, pix_valid, win_ready, new_buffer,
    output pix_ready, shift_en, shift_buffer, row_buffer_out
  );

  modport slave (
    output pix_data, pix_valid, win_ready, new_buffer,
    input  pix_ready, shift_en, shift_buffer, row_buffer_out
  );
endinterface

// File: rtl/conv_window_sequencer.sv
// Sequences one image frame through the window-shift stage: fills FILTER_SIZE rows,
// sweeps each row under win_ready back-pressure, then loads one new row per output row.
module conv_window_sequencer #(
  parameter int IMAGE_WIDTH  = 9,
  parameter int IMAGE_HEIGHT = 9,
  parameter int FILTER_SIZE  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic frame_done,
  output logic seq_err,
  conv_window_sequencer_if.master bus
);
  localparam int WPR      = IMAGE_WIDTH - FILTER_SIZE + 1;
  localparam int OUT_ROWS = IMAGE_HEIGHT - FILTER_SIZE + 1;
  localparam int ROW_BITS = IMAGE_WIDTH * 8;
  localparam int BUF_BITS = FILTER_SIZE * ROW_BITS;
  localparam int CW       = $clog2(IMAGE_WIDTH) + 1;
  localparam int RW       = $clog2(FILTER_SIZE) + 1;
  localparam int PW       = $clog2(WPR) + 1;
  localparam int OW       = $clog2(OUT_ROWS) + 1;

  typedef enum logic [2:0] {IDLE, FILL, START, SWEEP, WAIT_NB, LOAD, DONE} state_t;

  state_t              state, state_next;
  logic [CW-1:0]       col_cnt;
  logic [RW-1:0]       rows_loaded;
  logic [PW-1:0]       pulse_cnt;
  logic [OW-1:0]       out_row;
  logic [1:0]          wait_cnt;
  logic [ROW_BITS-1:0] staging, staging_next;
  logic [BUF_BITS-1:0] row_buf;

  logic pix_ready_c, shift_en_c, shift_buffer_c, frame_done_c;
  logic xfer, commit, wait_expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next     = state;
    pix_ready_c    = 1'b0;
    shift_en_c     = 1'b0;
    shift_buffer_c = 1'b0;
    frame_done_c   = 1'b0;
    xfer           = 1'b0;
    commit         = 1'b0;
    wait_expire    = 1'b0;
    case (state)
      IDLE: if (start) state_next = FILL;
      FILL, LOAD: begin
        pix_ready_c = 1'b1;
        xfer        = bus.pix_valid;
        commit      = bus.pix_valid && (col_cnt == CW'(IMAGE_WIDTH - 1));
        if (commit && (state == LOAD || rows_loaded == RW'(FILTER_SIZE - 1)))
          state_next = START;
      end
      START: begin
        shift_en_c = 1'b1;
        state_next = SWEEP;
      end
      SWEEP: begin
        shift_buffer_c = bus.win_ready;
        if (bus.win_ready && pulse_cnt == PW'(WPR - 1)) state_next = WAIT_NB;
      end
      WAIT_NB: begin
        if (bus.new_buffer) begin
          state_next = (out_row == OW'(OUT_ROWS - 1)) ? DONE : LOAD;
        end else if (wait_cnt == 2'd1) begin
          // The shift stage missed its end-of-row pulse: abandon the frame.
          wait_expire = 1'b1;
          state_next  = IDLE;
        end
      end
      DONE: begin
        frame_done_c = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    staging_next = staging;
    for (int c = 0; c < IMAGE_WIDTH; c++)
      if (col_cnt == CW'(c)) staging_next[c*8 +: 8] = bus.pix_data;
  end

  // Counters, staging row and the row buffer; the buffer only moves on a row commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt     <= '0;
      rows_loaded <= '0;
      pulse_cnt   <= '0;
      out_row     <= '0;
      wait_cnt    <= '0;
      staging     <= '0;
      row_buf     <= '0;
      seq_err     <= 1'b0;
    end else begin
      if (state == IDLE) begin
        col_cnt     <= '0;
        rows_loaded <= '0;
        out_row     <= '0;
      end
      if (xfer) begin
        staging <= staging_next;
        col_cnt <= commit ? '0 : col_cnt + CW'(1);
      end
      if (commit) begin
        for (int r = 0; r < FILTER_SIZE - 1; r++)
          row_buf[r*ROW_BITS +: ROW_BITS] <= row_buf[(r+1)*ROW_BITS +: ROW_BITS];
        row_buf[(FILTER_SIZE-1)*ROW_BITS +: ROW_BITS] <= staging_next;
        if (rows_loaded < RW'(FILTER_SIZE)) rows_loaded <= rows_loaded + RW'(1);
      end
      if (state == START)  pulse_cnt <= '0;
      else if (shift_buffer_c) pulse_cnt <= pulse_cnt + PW'(1);
      if (state == WAIT_NB && !bus.new_buffer) wait_cnt <= wait_cnt + 2'd1;
      else                                     wait_cnt <= '0;
      if (state == WAIT_NB && bus.new_buffer) out_row <= out_row + OW'(1);
      if ((bus.new_buffer && state != WAIT_NB) || wait_expire) seq_err <= 1'b1;
    end
  end

  assign bus.pix_ready      = pix_ready_c;
  assign bus.shift_en       = shift_en_c;
  assign bus.shift_buffer   = shift_buffer_c;
  assign bus.row_buffer_out = row_buf;
  assign frame_done         = frame_done_c;
  assign busy               = (state != IDLE);
endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench for conv_window_sequencer: a frame table plus hand-written corner sequences.
// A small shift-stage model answers each WPR-th shift_buffer pulse with new_buffer.
module tb_conv_window_sequencer;
  localparam int IW       = 9;
  localparam int IH       = 9;
  localparam int FS       = 3;
  localparam int WPR      = IW - FS + 1;
  localparam int BUF_BITS = FS * IW * 8;

  typedef struct {
    int valid_mode;
    int win_mode;
    int exp_shift_en;
    int exp_shift_buf;
    int exp_new_buf;
    int exp_done;
    int exp_lat;
    int len_lo;
    int len_hi;
    int exp_commits;
    int exp_pixels;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, frame_done, seq_err;

  conv_window_sequencer_if #(.IMAGE_WIDTH(IW), .FILTER_SIZE(FS)) bus ();

  conv_window_sequencer #(.IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .FILTER_SIZE(FS)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .frame_done(frame_done), .seq_err(seq_err), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pix_idx = 0;
  bit last_xfer = 0;
  int valid_mode = 0;
  int win_mode = 0;
  bit nb_pend = 0;
  bit nb_force = 0;
  bit nb_withhold = 0;
  int se_cnt = 0, sb_cnt = 0, nb_cnt = 0, fd_cnt = 0, lp_cnt = 0, sb_model = 0;
  int rb_changes = 0, start_cyc = 0, done_cyc = 0;
  int sweep_len = 0, min_len = 1000, max_len = 0;
  bit sweeping = 0, busy_prev = 0;
  logic [BUF_BITS-1:0] prev_rb = '0, snap_first = '0, snap_last = '0;

  // Stimulus driver, shift-stage model and monitor; outputs sampled 1 ns after the falling edge.
  initial begin
    bus.pix_data   = '0;
    bus.pix_valid  = 1'b0;
    bus.win_ready  = 1'b0;
    bus.new_buffer = 1'b0;
    forever begin
      @(negedge clk);
      if (last_xfer) pix_idx++;
      cyc++;
      bus.win_ready  = (win_mode == 0) ? 1'b1 : cyc[0];
      bus.pix_valid  = (valid_mode == 0) ? 1'b1 : (cyc % 3 == 0);
      bus.pix_data   = 8'(pix_idx);
      bus.new_buffer = (nb_pend && !nb_withhold) || nb_force;
      nb_pend = 1'b0;
      #1;
      last_xfer = bus.pix_valid && bus.pix_ready;
      if (bus.new_buffer) nb_cnt++;
      if (frame_done) begin fd_cnt++; done_cyc = cyc; end
      if (busy && !busy_prev) start_cyc = cyc;
      busy_prev = busy;
      if (bus.row_buffer_out != prev_rb) rb_changes++;
      prev_rb = bus.row_buffer_out;
      if (sweeping) sweep_len++;
      if (bus.shift_buffer) begin
        sb_cnt++;
        sb_model++;
        if (sb_model == WPR) begin
          nb_pend = 1'b1;
          lp_cnt++;
          if (sweeping) begin
            if (sweep_len < min_len) min_len = sweep_len;
            if (sweep_len > max_len) max_len = sweep_len;
          end
          sweeping = 1'b0;
        end
      end
      if (bus.shift_en) begin
        if (se_cnt == 0) snap_first = bus.row_buffer_out;
        snap_last = bus.row_buffer_out;
        se_cnt++;
        sb_model  = 0;
        sweeping  = 1'b1;
        sweep_len = 0;
      end
    end
  end

  function automatic logic [BUF_BITS-1:0] expWin(int base);
    logic [BUF_BITS-1:0] v;
    v = '0;
    for (int i = 0; i < FS * IW; i++) v[i*8 +: 8] = 8'(base + i);
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    total++;
    if (actual < lo || actual > hi) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic checkWindow(input string name, input logic [BUF_BITS-1:0] actual,
                             input logic [BUF_BITS-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk); #2;
    rst = 1'b1;
    @(negedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic startFrame();
    @(negedge clk); #2;
    pix_idx = 0; last_xfer = 1'b0;
    se_cnt = 0; sb_cnt = 0; nb_cnt = 0; fd_cnt = 0; lp_cnt = 0;
    rb_changes = 0; min_len = 1000; max_len = 0; sweeping = 1'b0;
    start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
  endtask

  task automatic waitFrame(input int budget);
    int n;
    n = 0;
    while (fd_cnt == 0 && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    if (fd_cnt == 0) checkOutput("frame_timeout", 0, 1);
    @(negedge clk); #2;
  endtask

  task automatic waitShiftEn(input int target, input int budget);
    int n;
    n = 0;
    while (se_cnt < target && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    if (se_cnt < target) checkOutput("shift_en_timeout", se_cnt, target);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    valid_mode = v.valid_mode;
    win_mode   = v.win_mode;
    startFrame();
    waitFrame(3000);
    $display("[TB] frame %0d: valid_mode=%0d win_mode=%0d", idx, v.valid_mode, v.win_mode);
    checkOutput($sformatf("v%0d_shift_en", idx), se_cnt, v.exp_shift_en);
    checkOutput($sformatf("v%0d_shift_buf", idx), sb_cnt, v.exp_shift_buf);
    checkOutput($sformatf("v%0d_new_buf", idx), nb_cnt, v.exp_new_buf);
    checkOutput($sformatf("v%0d_done", idx), fd_cnt, v.exp_done);
    checkOutput($sformatf("v%0d_commits", idx), rb_changes, v.exp_commits);
    checkOutput($sformatf("v%0d_pixels", idx), pix_idx, v.exp_pixels);
    checkOutput($sformatf("v%0d_seq_err", idx), seq_err, 0);
    checkOutput($sformatf("v%0d_busy_after", idx), busy, 0);
    checkRange($sformatf("v%0d_sweep_min", idx), min_len, v.len_lo, v.len_hi);
    checkRange($sformatf("v%0d_sweep_max", idx), max_len, v.len_lo, v.len_hi);
    checkWindow($sformatf("v%0d_first_win", idx), snap_first, expWin(0));
    checkWindow($sformatf("v%0d_last_win", idx), snap_last, expWin(54));
    if (v.exp_lat >= 0)
      checkOutput($sformatf("v%0d_latency", idx), done_cyc - start_cyc + 1, v.exp_lat);
  endtask

  initial begin
    vec_t vecs[3];
    int n;
    vecs[0] = '{0, 0, 7, 49, 7, 1, 145, 7, 7, 9, 81};
    vecs[1] = '{0, 1, 7, 49, 7, 1, -1, 13, 14, 9, 81};
    vecs[2] = '{1, 0, 7, 49, 7, 1, -1, 7, 7, 9, 81};

    // Reset state
    @(negedge clk); #2;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_pix_ready", bus.pix_ready, 0);
    checkOutput("rst_shift_en", bus.shift_en, 0);
    checkOutput("rst_shift_buf", bus.shift_buffer, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_seq_err", seq_err, 0);
    checkWindow("rst_row_buf", bus.row_buffer_out, '0);
    rst = 1'b0;
    @(negedge clk); #2;
    checkOutput("idle_busy", busy, 0);

    for (int i = 0; i < 3; i++) applyStimulus(vecs[i], i);

    // Reset during the third sweep, then a fresh frame
    valid_mode = 0;
    win_mode   = 0;
    startFrame();
    waitShiftEn(3, 1000);
    @(negedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_pix_ready", bus.pix_ready, 0);
    checkOutput("midrst_shift_en", bus.shift_en, 0);
    checkOutput("midrst_shift_buf", bus.shift_buffer, 0);
    checkOutput("midrst_frame_done", frame_done, 0);
    checkWindow("midrst_row_buf", bus.row_buffer_out, '0);
    @(negedge clk); #2;
    rst = 1'b0;
    applyStimulus(vecs[0], 3);

    // new_buffer forced high during FILL
    startFrame();
    repeat (5) @(negedge clk);
    #2 nb_force = 1'b1;
    @(negedge clk); #2;
    nb_force = 1'b0;
    @(negedge clk); #2;
    checkOutput("force_seq_err_set", seq_err, 1);
    waitFrame(3000);
    checkOutput("force_done", fd_cnt, 1);
    checkOutput("force_seq_err_sticky", seq_err, 1);
    checkWindow("force_last_win", snap_last, expWin(54));
    doReset();
    checkOutput("force_seq_err_clr", seq_err, 0);

    // new_buffer withheld: two WAIT_NB cycles, then error and IDLE
    nb_withhold = 1'b1;
    startFrame();
    n = 0;
    while (lp_cnt == 0 && n < 1000) begin
      @(negedge clk); #2;
      n++;
    end
    if (lp_cnt == 0) checkOutput("withhold_timeout", 0, 1);
    @(negedge clk); #2;
    checkOutput("withhold_w1_busy", busy, 1);
    checkOutput("withhold_w1_err", seq_err, 0);
    @(negedge clk); #2;
    checkOutput("withhold_w2_busy", busy, 1);
    @(negedge clk); #2;
    checkOutput("withhold_idle", busy, 0);
    checkOutput("withhold_err", seq_err, 1);
    nb_withhold = 1'b0;
    doReset();

    // start pulsed while busy is ignored
    startFrame();
    repeat (10) @(negedge clk);
    #2 start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
    waitShiftEn(2, 1000);
    start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
    waitFrame(3000);
    checkOutput("busystart_done", fd_cnt, 1);
    checkOutput("busystart_shift_en", se_cnt, 7);
    checkOutput("busystart_shift_buf", sb_cnt, 49);
    checkWindow("busystart_last_win", snap_last, expWin(54));
    repeat (3) @(negedge clk);
    #2;
    checkOutput("busystart_idle", busy, 0);
    checkOutput("busystart_one_done", fd_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
